// File: rtl/template_word_dispatch_pkg.sv
// Shared definitions for the word-storage read dispatcher: FSM encoding,
// the MSB helper macro and the byte-bus width.
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package template_word_dispatch_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ARB        = 3'd1,
      ST_XFER       = 3'd2,
      ST_DONE       = 3'd3,
      ST_SETTLE     = 3'd4,
      ST_BCAST_WAIT = 3'd5,
      ST_BCAST      = 3'd6
   } state_e;

endpackage

// File: rtl/template_word_dispatch_rr_arbiter_n.sv
// Round-robin arbiter: one-hot grant to the first requester after the last
// granted unit; the pointer moves only when the grant is consumed.
module rr_arbiter_n #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last_q;
   logic [PW-1:0] last_d;
   logic [PW-1:0] pick_s;
   logic [PW:0]   sum_s;
   logic          found_s;

   // Cyclic search starting one past the last granted unit.
   always_comb begin
      grant   = {N{1'b0}};
      pick_s  = last_q;
      found_s = 1'b0;
      sum_s   = {(PW+1){1'b0}};
      for (int i = 1; i <= N; i++) begin
         sum_s = {1'b0, last_q} + (PW+1)'(i);
         if (sum_s >= (PW+1)'(N)) begin
            sum_s = sum_s - (PW+1)'(N);
         end else begin
            sum_s = sum_s;
         end
         if (!found_s && req[sum_s[PW-1:0]]) begin
            found_s = 1'b1;
            pick_s  = sum_s[PW-1:0];
         end else begin
            found_s = found_s;
         end
      end
      if (found_s) begin
         grant[pick_s] = 1'b1;
      end else begin
         grant = {N{1'b0}};
      end
      last_d = (advance && found_s) ? pick_s : last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PW'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/template_word_dispatch.sv
// Read-side scheduler for the shared word storage: grants the stored word to one
// requesting unit, streams its bytes, releases storage, and broadcasts end-of-list.
module template_word_dispatch
   import template_word_dispatch_pkg::*;
#(
   parameter int N_UNITS        = 4,
   parameter int WORD_MAX_LEN   = 64,
   parameter int RANGES_MAX     = 8,
   parameter int RANGE_INFO_MSB = 1 + `MSB(WORD_MAX_LEN - 1)
) (
   input  logic                                      CLK,
   input  logic                                      RESET_N,
   input  logic                                      src_empty,
   input  logic [BYTE_W-1:0]                         src_dout,
   output logic [`MSB(WORD_MAX_LEN-1):0]             src_rd_addr,
   output logic                                      src_set_empty,
   input  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]  src_range_info,
   input  logic [15:0]                               src_word_id,
   input  logic                                      src_word_list_end,
   input  logic [N_UNITS-1:0]                        unit_req,
   output logic [N_UNITS-1:0]                        unit_wr_en,
   output logic [`MSB(WORD_MAX_LEN-1):0]             unit_wr_addr,
   output logic [BYTE_W-1:0]                         unit_dout,
   output logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]  unit_range_info,
   output logic [15:0]                               unit_word_id,
   output logic                                      unit_word_list_end,
   output logic [N_UNITS-1:0]                        unit_word_done,
   output logic                                      busy
);

   localparam int AW  = `MSB(WORD_MAX_LEN - 1) + 1;
   localparam int RIW = RANGES_MAX * (RANGE_INFO_MSB + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_MAX_LEN - 1);

   state_e               state_q, state_d;
   logic [AW-1:0]        rd_addr_q, rd_addr_d;
   logic [N_UNITS-1:0]   grant_q, grant_d;
   logic [RIW-1:0]       ri_q, ri_d;
   logic [15:0]          id_q, id_d;
   logic [N_UNITS-1:0]   wr_en_q, wr_en_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic [N_UNITS-1:0]   done_q, done_d;
   logic                 set_empty_q, set_empty_d;
   logic                 list_end_q, list_end_d;
   logic                 busy_q, busy_d;
   logic                 advance_s;
   logic                 last_strobe_s;
   logic [N_UNITS-1:0]   arb_grant_s;

   rr_arbiter_n #(
      .N(N_UNITS)
   ) u_arb (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .req     (unit_req),
      .advance (advance_s),
      .grant   (arb_grant_s)
   );

   // The strobe for the final address is on the bus this cycle; XFER ends here.
   assign last_strobe_s = (|wr_en_q) && (wr_addr_q == LAST_ADDR);

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      grant_d     = grant_q;
      ri_d        = ri_q;
      id_d        = id_q;
      wr_en_d     = {N_UNITS{1'b0}};
      wr_addr_d   = {AW{1'b0}};
      done_d      = {N_UNITS{1'b0}};
      set_empty_d = 1'b0;
      list_end_d  = 1'b0;
      advance_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rd_addr_d = {AW{1'b0}};
            if (!src_empty) begin
               state_d = src_word_list_end ? ST_BCAST_WAIT : ST_ARB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (|unit_req) begin
               advance_s = 1'b1;
               grant_d   = arb_grant_s;
               ri_d      = src_range_info;
               id_d      = src_word_id;
               rd_addr_d = {AW{1'b0}};
               state_d   = ST_XFER;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_XFER: begin
            // Read data lags the address by one cycle, so the bus replays the old address.
            if (last_strobe_s) begin
               rd_addr_d   = {AW{1'b0}};
               done_d      = grant_q;
               set_empty_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               rd_addr_d = (rd_addr_q == LAST_ADDR) ? {AW{1'b0}} : rd_addr_q + AW'(1);
               wr_en_d   = grant_q;
               wr_addr_d = rd_addr_q;
               state_d   = ST_XFER;
            end
         end
         ST_DONE: begin
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            state_d = ST_IDLE;
         end
         ST_BCAST_WAIT: begin
            if (&unit_req) begin
               done_d      = {N_UNITS{1'b1}};
               list_end_d  = 1'b1;
               set_empty_d = 1'b1;
               state_d     = ST_BCAST;
            end else begin
               state_d = ST_BCAST_WAIT;
            end
         end
         ST_BCAST: begin
            state_d = ST_SETTLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         rd_addr_q   <= {AW{1'b0}};
         grant_q     <= {N_UNITS{1'b0}};
         ri_q        <= {RIW{1'b0}};
         id_q        <= 16'h0000;
         wr_en_q     <= {N_UNITS{1'b0}};
         wr_addr_q   <= {AW{1'b0}};
         done_q      <= {N_UNITS{1'b0}};
         set_empty_q <= 1'b0;
         list_end_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         grant_q     <= grant_d;
         ri_q        <= ri_d;
         id_q        <= id_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         done_q      <= done_d;
         set_empty_q <= set_empty_d;
         list_end_q  <= list_end_d;
         busy_q      <= busy_d;
      end
   end

   assign src_rd_addr        = rd_addr_q;
   assign src_set_empty      = set_empty_q;
   assign unit_wr_en         = wr_en_q;
   assign unit_wr_addr       = wr_addr_q;
   assign unit_dout          = (|wr_en_q) ? src_dout : {BYTE_W{1'b0}};
   assign unit_range_info    = ri_q;
   assign unit_word_id       = id_q;
   assign unit_word_list_end = list_end_q;
   assign unit_word_done     = done_q;
   assign busy               = busy_q;

endmodule
